// File: rtl/idu_decode_stage_pkg.sv
// Shared decode constants, ALU operation/source encodings and the decoded-instruction record.
package idu_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALUOP_OR  = 4'd0,
        ALUOP_AND = 4'd1,
        ALUOP_ADD = 4'd2,
        ALUOP_SUB = 4'd3,
        ALUOP_XOR = 4'd4,
        ALUOP_NOR = 4'd5,
        ALUOP_SLL = 4'd6,
        ALUOP_SRL = 4'd7,
        ALUOP_SRA = 4'd8
    } aluop_e;

    typedef enum logic [2:0] {
        SRC_RT  = 3'd0,
        SRC_IMM = 3'd1,
        SRC_SA  = 3'd2,
        SRC_PC  = 3'd3
    } alu_src_e;

    typedef enum logic {
        ST_RUN,
        ST_STALLED
    } stall_st_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef struct packed {
        aluop_e      aluop;
        alu_src_e    alu_src;
        logic [31:0] ext_imm;
        logic [4:0]  sa;
        logic [4:0]  waddr;
        logic        wen;
        logic        is_load;
        logic        is_store;
        logic        use_rs;
        logic        use_rt;
        logic        rs_zero;
    } dec_t;

endpackage

// File: rtl/idu_decode_stage_fwd_mux.sv
// Operand forwarding select: EX (non-load) result, then MEM write data, then regfile data.
module fwd_mux
    import idu_decode_stage_pkg::*;
(
    input  logic [4:0]  raddr,
    input  logic [31:0] rf_data,
    input  logic        ex_wen,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] fwd_data
);

    // Youngest producer wins; register 0 always reads the regfile.
    always_comb begin
        fwd_data = rf_data;
        if (raddr != REG_ZERO) begin
            if (ex_wen && !ex_is_load && (ex_waddr == raddr)) begin
                fwd_data = ex_result;
            end else if (mem_wen && (mem_waddr == raddr)) begin
                fwd_data = mem_wdata;
            end
        end
    end

endmodule

// File: rtl/idu_decode_stage.sv
// ID stage: decode, regfile read, forwarding, load-use stall and ID/EX pipeline register.
module idu_decode_stage
    import idu_decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic [4:0]  raddr1,
    output logic [4:0]  raddr2,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic        ex_wen,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        out_valid,
    output logic [3:0]  aluop,
    output logic [2:0]  alu_src,
    output logic [31:0] rdata1_out,
    output logic [31:0] rdata2_out,
    output logic [31:0] ext_imm,
    output logic [4:0]  sa,
    output logic [31:0] pc_out,
    output logic [4:0]  waddr,
    output logic        wen,
    output logic        is_load,
    output logic        is_store
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] jtarget;
    dec_t        dec;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        hazard;
    logic        stall;
    logic        issue;
    stall_st_e   state;
    stall_st_e   state_nxt;

    assign opcode   = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign funct    = inst[5:0];
    assign sext_imm = {{16{inst[15]}}, inst[15:0]};
    assign zext_imm = {16'h0000, inst[15:0]};
    assign jtarget  = {6'b000000, inst[25:0]};

    // Instruction decode; anything unrecognised becomes a non-writing OR/rt NOP.
    always_comb begin
        dec         = '0;
        dec.aluop   = ALUOP_OR;
        dec.alu_src = SRC_RT;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        case (funct)
                            FN_ADDU: dec.aluop = ALUOP_ADD;
                            FN_SUBU: dec.aluop = ALUOP_SUB;
                            FN_AND:  dec.aluop = ALUOP_AND;
                            FN_XOR:  dec.aluop = ALUOP_XOR;
                            FN_NOR:  dec.aluop = ALUOP_NOR;
                            default: dec.aluop = ALUOP_OR;
                        endcase
                        dec.waddr  = rd;
                        dec.wen    = 1'b1;
                        dec.use_rs = 1'b1;
                        dec.use_rt = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        case (funct)
                            FN_SLL:  dec.aluop = ALUOP_SLL;
                            FN_SRL:  dec.aluop = ALUOP_SRL;
                            default: dec.aluop = ALUOP_SRA;
                        endcase
                        dec.alu_src = SRC_SA;
                        dec.sa      = inst[10:6];
                        dec.waddr   = rd;
                        dec.wen     = 1'b1;
                        dec.use_rt  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_LW: begin
                dec.aluop   = ALUOP_ADD;
                dec.alu_src = SRC_IMM;
                dec.ext_imm = sext_imm;
                dec.waddr   = rt;
                dec.wen     = 1'b1;
                dec.is_load = (opcode == OP_LW);
                dec.use_rs  = 1'b1;
            end
            OP_SW: begin
                dec.aluop    = ALUOP_ADD;
                dec.alu_src  = SRC_IMM;
                dec.ext_imm  = sext_imm;
                dec.is_store = 1'b1;
                dec.use_rs   = 1'b1;
                dec.use_rt   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                case (opcode)
                    OP_ANDI: dec.aluop = ALUOP_AND;
                    OP_XORI: dec.aluop = ALUOP_XOR;
                    default: dec.aluop = ALUOP_OR;
                endcase
                dec.alu_src = SRC_IMM;
                dec.ext_imm = zext_imm;
                dec.waddr   = rt;
                dec.wen     = 1'b1;
                dec.use_rs  = 1'b1;
            end
            OP_LUI: begin
                dec.alu_src = SRC_IMM;
                dec.ext_imm = {inst[15:0], 16'h0000};
                dec.waddr   = rt;
                dec.wen     = 1'b1;
                dec.rs_zero = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.aluop   = ALUOP_SUB;
                dec.ext_imm = sext_imm;
                dec.use_rs  = 1'b1;
                dec.use_rt  = 1'b1;
            end
            OP_J: begin
                dec.ext_imm = jtarget;
            end
            OP_JAL: begin
                dec.aluop   = ALUOP_ADD;
                dec.alu_src = SRC_PC;
                dec.ext_imm = jtarget;
                dec.waddr   = REG_RA;
                dec.wen     = 1'b1;
            end
            default: ;
        endcase
    end

    assign raddr1 = dec.rs_zero ? REG_ZERO : rs;
    assign raddr2 = rt;

    fwd_mux u_fwd_rs (
        .raddr      (raddr1),
        .rf_data    (rdata1),
        .ex_wen     (ex_wen),
        .ex_waddr   (ex_waddr),
        .ex_result  (ex_result),
        .ex_is_load (ex_is_load),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .fwd_data   (fwd1)
    );

    fwd_mux u_fwd_rt (
        .raddr      (raddr2),
        .rf_data    (rdata2),
        .ex_wen     (ex_wen),
        .ex_waddr   (ex_waddr),
        .ex_result  (ex_result),
        .ex_is_load (ex_is_load),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .fwd_data   (fwd2)
    );

    assign hazard = ex_is_load && ex_wen && (ex_waddr != REG_ZERO) &&
                    ((dec.use_rs && (ex_waddr == raddr1)) ||
                     (dec.use_rt && (ex_waddr == raddr2)));

    // Stall tracker register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A load-use hazard stalls once; the cycle after, the load has moved to MEM so the
    // same hazard seen again is ignored. Flush kills the stall outright.
    always_comb begin
        stall     = 1'b0;
        state_nxt = ST_RUN;
        if ((state == ST_RUN) && in_valid && hazard && !flush) begin
            stall     = 1'b1;
            state_nxt = ST_STALLED;
        end
    end

    assign in_ready = !stall;
    assign issue    = in_valid && in_ready && !flush;

    // ID/EX register: issue the decoded instruction, otherwise insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            aluop      <= '0;
            alu_src    <= '0;
            rdata1_out <= '0;
            rdata2_out <= '0;
            ext_imm    <= '0;
            sa         <= '0;
            pc_out     <= RESET_PC;
            waddr      <= '0;
            wen        <= 1'b0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            aluop      <= dec.aluop;
            alu_src    <= dec.alu_src;
            rdata1_out <= fwd1;
            rdata2_out <= fwd2;
            ext_imm    <= dec.ext_imm;
            sa         <= dec.sa;
            pc_out     <= pc_in;
            waddr      <= dec.waddr;
            wen        <= dec.wen;
            is_load    <= dec.is_load;
            is_store   <= dec.is_store;
        end else begin
            out_valid  <= 1'b0;
            wen        <= 1'b0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_decode_stage.sv
// Self-checking bench for idu_decode_stage: directed cases plus randomized traffic
// checked against a table-driven reference model.
module tb_idu_decode_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc_in;
    logic        flush;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ex_wen;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic [3:0]  aluop;
    logic [2:0]  alu_src;
    logic [31:0] rdata1_out;
    logic [31:0] rdata2_out;
    logic [31:0] ext_imm;
    logic [4:0]  sa;
    logic [31:0] pc_out;
    logic [4:0]  waddr;
    logic        wen;
    logic        is_load;
    logic        is_store;

    idu_decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc_in(pc_in), .flush(flush),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_result(ex_result), .ex_is_load(ex_is_load),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .aluop(aluop), .alu_src(alu_src),
        .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .ext_imm(ext_imm), .sa(sa),
        .pc_out(pc_out), .waddr(waddr), .wen(wen), .is_load(is_load), .is_store(is_store)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction description table: imm kind 0 none/1 sext/2 zext/3 lui/4 jump target;
    // dst kind 0 none/1 rd/2 rt/3 ra.
    typedef struct {
        bit [5:0]    op;
        bit [5:0]    fn;
        bit          rtype;
        int unsigned aluop;
        int unsigned src;
        int unsigned imm;
        int unsigned dst;
        bit          ld;
        bit          st;
        bit          urs;
        bit          urt;
        bit          zr1;
        bit          shamt;
    } desc_t;

    desc_t tbl[$];

    int n_checks = 0;
    int n_errors = 0;

    // Expected ID/EX contents and stall history.
    logic        e_valid;
    logic [3:0]  e_aluop;
    logic [2:0]  e_src;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_imm;
    logic [4:0]  e_sa;
    logic [31:0] e_pc;
    logic [4:0]  e_waddr;
    logic        e_wen;
    logic        e_ld;
    logic        e_st;
    bit          m_stalled;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic def(input bit [5:0] op, input bit [5:0] fn, input bit rtype,
                       input int unsigned alu, input int unsigned src, input int unsigned imm,
                       input int unsigned dst, input bit ld, input bit st, input bit urs,
                       input bit urt, input bit zr1, input bit shamt);
        desc_t d;
        d.op = op; d.fn = fn; d.rtype = rtype; d.aluop = alu; d.src = src; d.imm = imm;
        d.dst = dst; d.ld = ld; d.st = st; d.urs = urs; d.urt = urt; d.zr1 = zr1; d.shamt = shamt;
        tbl.push_back(d);
    endtask

    function automatic int find(input logic [31:0] i);
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rtype && i[31:26] == 6'h00 && i[5:0] == tbl[k].fn) return k;
            if (!tbl[k].rtype && i[31:26] == tbl[k].op) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (ex_wen && !ex_is_load && ex_waddr == a) return ex_result;
        if (mem_wen && mem_waddr == a) return mem_wdata;
        return rf;
    endfunction

    task automatic reset_model();
        e_valid = 0; e_aluop = 0; e_src = 0; e_r1 = 0; e_r2 = 0; e_imm = 0; e_sa = 0;
        e_pc = RST_PC; e_waddr = 0; e_wen = 0; e_ld = 0; e_st = 0; m_stalled = 0;
    endtask

    task automatic quiet();
        in_valid = 0; flush = 0; inst = 0; pc_in = $urandom;
        rdata1 = $urandom; rdata2 = $urandom;
        ex_wen = 0; ex_waddr = 0; ex_result = $urandom; ex_is_load = 0;
        mem_wen = 0; mem_waddr = 0; mem_wdata = $urandom;
    endtask

    // One clock: check combinational outputs, predict and check the ID/EX register.
    task automatic step();
        desc_t      d;
        int         idx;
        logic [4:0] r1;
        logic [4:0] r2;
        bit         haz;
        bit         stall;
        d = '{default: 0};
        idx = find(inst);
        if (idx >= 0) d = tbl[idx];
        r1 = d.zr1 ? 5'd0 : inst[25:21];
        r2 = inst[20:16];
        haz = ex_is_load && ex_wen && ex_waddr != 0 &&
              ((d.urs && ex_waddr == r1) || (d.urt && ex_waddr == r2));
        stall = in_valid && haz && !m_stalled && !flush;
        #1;
        chk("raddr1", {27'd0, raddr1}, {27'd0, r1});
        chk("raddr2", {27'd0, raddr2}, {27'd0, r2});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !stall});
        if (flush || !in_valid || stall) begin
            e_valid = 0; e_wen = 0; e_ld = 0; e_st = 0;
        end else begin
            e_valid = 1;
            e_aluop = 4'(d.aluop);
            e_src   = 3'(d.src);
            e_r1    = fwd(r1, rdata1);
            e_r2    = fwd(r2, rdata2);
            case (d.imm)
                1: e_imm = {{16{inst[15]}}, inst[15:0]};
                2: e_imm = {16'h0, inst[15:0]};
                3: e_imm = {inst[15:0], 16'h0};
                4: e_imm = {6'h0, inst[25:0]};
                default: e_imm = 0;
            endcase
            e_sa = d.shamt ? inst[10:6] : 5'd0;
            e_pc = pc_in;
            case (d.dst)
                1: e_waddr = inst[15:11];
                2: e_waddr = inst[20:16];
                3: e_waddr = 5'd31;
                default: e_waddr = 0;
            endcase
            e_wen = (d.dst != 0);
            e_ld  = d.ld;
            e_st  = d.st;
        end
        m_stalled = stall;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        chk("aluop", {28'd0, aluop}, {28'd0, e_aluop});
        chk("alu_src", {29'd0, alu_src}, {29'd0, e_src});
        chk("rdata1_out", rdata1_out, e_r1);
        chk("rdata2_out", rdata2_out, e_r2);
        chk("ext_imm", ext_imm, e_imm);
        chk("sa", {27'd0, sa}, {27'd0, e_sa});
        chk("pc_out", pc_out, e_pc);
        chk("waddr", {27'd0, waddr}, {27'd0, e_waddr});
        chk("wen", {31'd0, wen}, {31'd0, e_wen});
        chk("is_load", {31'd0, is_load}, {31'd0, e_ld});
        chk("is_store", {31'd0, is_store}, {31'd0, e_st});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_aluop"}, {28'd0, aluop}, 32'd0);
        chk({tag, "_r1"}, rdata1_out, 32'd0);
        chk({tag, "_imm"}, ext_imm, 32'd0);
        chk({tag, "_waddr"}, {27'd0, waddr}, 32'd0);
        chk({tag, "_wen"}, {31'd0, wen}, 32'd0);
        chk({tag, "_pc"}, pc_out, RST_PC);
    endtask

    localparam logic [31:0] I_ADDU = 32'h010B5021; // ADDU $10,$8,$11

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        //  op     fn     r  alu src imm dst ld st rs rt z1 sh
        def(6'h00, 6'h21, 1, 2, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h23, 1, 3, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h24, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h25, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h26, 1, 4, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h27, 1, 5, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        def(6'h00, 6'h00, 1, 6, 2, 0, 1, 0, 0, 0, 1, 0, 1);
        def(6'h00, 6'h02, 1, 7, 2, 0, 1, 0, 0, 0, 1, 0, 1);
        def(6'h00, 6'h03, 1, 8, 2, 0, 1, 0, 0, 0, 1, 0, 1);
        def(6'h09, 6'h00, 0, 2, 1, 1, 2, 0, 0, 1, 0, 0, 0);
        def(6'h23, 6'h00, 0, 2, 1, 1, 2, 1, 0, 1, 0, 0, 0);
        def(6'h2B, 6'h00, 0, 2, 1, 1, 0, 0, 1, 1, 1, 0, 0);
        def(6'h0C, 6'h00, 0, 1, 1, 2, 2, 0, 0, 1, 0, 0, 0);
        def(6'h0D, 6'h00, 0, 0, 1, 2, 2, 0, 0, 1, 0, 0, 0);
        def(6'h0E, 6'h00, 0, 4, 1, 2, 2, 0, 0, 1, 0, 0, 0);
        def(6'h0F, 6'h00, 0, 0, 1, 3, 2, 0, 0, 0, 0, 1, 0);
        def(6'h04, 6'h00, 0, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        def(6'h05, 6'h00, 0, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        def(6'h02, 6'h00, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        def(6'h03, 6'h00, 0, 2, 3, 4, 3, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        quiet();
        #12;
        chk_reset_outputs("reset");
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset_model();

        // ADDIU $9,$8,-1
        quiet(); in_valid = 1; inst = 32'h2509FFFF; step();
        chk("t1_aluop", {28'd0, aluop}, 32'd2);
        chk("t1_src", {29'd0, alu_src}, 32'd1);
        chk("t1_imm", ext_imm, 32'hFFFFFFFF);
        chk("t1_waddr", {27'd0, waddr}, 32'd9);
        chk("t1_wen", {31'd0, wen}, 32'd1);

        // ANDI then SRA
        quiet(); in_valid = 1; inst = 32'h3109FFFF; step();
        chk("t2_andi_imm", ext_imm, 32'h0000FFFF);
        chk("t2_andi_aluop", {28'd0, aluop}, 32'd1);
        quiet(); in_valid = 1; inst = 32'h00094043; step();
        chk("t2_sra_aluop", {28'd0, aluop}, 32'd8);
        chk("t2_sra_src", {29'd0, alu_src}, 32'd2);
        chk("t2_sra_sa", {27'd0, sa}, 32'd1);
        chk("t2_sra_waddr", {27'd0, waddr}, 32'd8);

        // Forwarding priority
        quiet(); in_valid = 1; inst = I_ADDU; rdata1 = 32'hAAAA;
        ex_wen = 1; ex_waddr = 8; ex_result = 32'h11;
        mem_wen = 1; mem_waddr = 8; mem_wdata = 32'h22;
        step();
        chk("t3_ex_fwd", rdata1_out, 32'h11);
        ex_wen = 0; step();
        chk("t3_mem_fwd", rdata1_out, 32'h22);
        ex_wen = 1; ex_waddr = 0; mem_waddr = 0; step();
        chk("t3_no_fwd", rdata1_out, 32'hAAAA);

        // Load-use: one bubble, then issue
        quiet(); in_valid = 1; inst = I_ADDU;
        ex_wen = 1; ex_is_load = 1; ex_waddr = 8;
        step();
        chk("t4_bubble", {31'd0, out_valid}, 32'd0);
        step();
        chk("t4_issue", {31'd0, out_valid}, 32'd1);

        // Flush during stall
        quiet(); in_valid = 1; inst = I_ADDU;
        ex_wen = 1; ex_is_load = 1; ex_waddr = 11;
        step();
        chk("t5_stall", {31'd0, out_valid}, 32'd0);
        flush = 1;
        step();
        chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 0; in_valid = 0;
        step();
        chk("t5_no_stale", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while stalled
        quiet(); in_valid = 1; inst = 32'h2509FFFF; step();
        inst = I_ADDU; ex_wen = 1; ex_is_load = 1; ex_waddr = 8; step();
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t6_async");
        reset_model();
        #3 rst = 1'b0;
        quiet(); step();
        in_valid = 1; inst = I_ADDU; ex_wen = 1; ex_is_load = 1; ex_waddr = 8; step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned pick;
            logic [31:0] w;
            quiet();
            pick = $urandom_range(0, tbl.size());
            w = $urandom;
            if (pick < tbl.size()) begin
                w[31:26] = tbl[pick].rtype ? 6'h00 : tbl[pick].op;
                if (tbl[pick].rtype) w[5:0] = tbl[pick].fn;
            end
            w[25:21] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            w[15:11] = 5'($urandom_range(0, 7));
            inst       = w;
            in_valid   = ($urandom_range(0, 9) < 8);
            flush      = ($urandom_range(0, 9) == 0);
            ex_wen     = $urandom_range(0, 1);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_waddr   = 5'($urandom_range(0, 7));
            mem_wen    = $urandom_range(0, 1);
            mem_waddr  = 5'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
